// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch/PC-write flush and operand forwarding select.
// Latency: controls are combinational (zero cycles); no backpressure, stall/flush are outputs only.
module pipe_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] ra1_e;
    logic [3:0] ra2_e;
    logic [3:0] wa3_e;
    logic [3:0] wa3_m;
    logic [3:0] wa3_w;
    logic       ldr_stall;

    assign ldr_stall = MemtoRegE & ((RA1D == wa3_e) | (RA2D == wa3_e));

    assign StallF = ldr_stall | PCWrPendingF;
    assign StallD = ldr_stall;
    assign FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
    assign FlushE = ldr_stall | BranchTakenE;

    // Memory-stage result is newer than Writeback, so its match wins.
    assign ForwardAE = (RegWriteM && (ra1_e == wa3_m)) ? 2'b10 :
                       (RegWriteW && (ra1_e == wa3_w)) ? 2'b01 : 2'b00;
    assign ForwardBE = (RegWriteM && (ra2_e == wa3_m)) ? 2'b10 :
                       (RegWriteW && (ra2_e == wa3_w)) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            ra1_e <= 4'd0;
            ra2_e <= 4'd0;
            wa3_e <= 4'd0;
            wa3_m <= 4'd0;
            wa3_w <= 4'd0;
        end else begin
            wa3_w <= wa3_m;
            wa3_m <= wa3_e;
            // A bubble carries register 0; its RegWrite is cleared upstream so it never matches usefully.
            if (FlushE) begin
                ra1_e <= 4'd0;
                ra2_e <= 4'd0;
                wa3_e <= 4'd0;
            end else begin
                ra1_e <= RA1D;
                ra2_e <= RA2D;
                wa3_e <= WA3D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (CntClr) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF && (StallCount != '1))
                StallCount <= StallCount + CNT_ONE;
            if (FlushE && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule
